// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared pipeline widths and constants for the write-back stage
package wb_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux2.sv
// rtl/wb_mux2.sv - parameterised 2:1 mux, sel=1 picks in1
module wb_mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: registered register-file write bundle
module wb_stage #(
    parameter int DATA_W     = wb_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = wb_stage_pkg::REG_ADDR_W
) (
    output logic                  MEMWBRegWriteOut,
    output logic [DATA_W-1:0]     MEMWBWriteData,
    output logic [REG_ADDR_W-1:0] MEMWBDstOut,
    input  logic [REG_ADDR_W-1:0] MEMWBDst,
    input  logic [DATA_W-1:0]     MEMWBALUResult,
    input  logic [DATA_W-1:0]     MEMWBReadData,
    input  logic                  MEMWBMemtoReg,
    input  logic                  MEMWBRegWrite,
    input  logic                  clock,
    input  logic                  reset
);

    import wb_stage_pkg::*;

    logic                  reg_write_d, reg_write_q;
    logic [DATA_W-1:0]     write_data_d, write_data_q;
    logic [REG_ADDR_W-1:0] dst_d, dst_q;
    logic [DATA_W-1:0]     mux_out;

    wb_mux2 #(.W(DATA_W)) u_mux (
        .sel (MEMWBMemtoReg),
        .in0 (MEMWBALUResult),
        .in1 (MEMWBReadData),
        .out (mux_out)
    );

    // Data and destination always follow the inputs; only the enable is gated,
    // and a write to $zero is dropped here so the register file never sees it.
    always_comb begin
        write_data_d = mux_out;
        dst_d        = MEMWBDst;
        reg_write_d  = MEMWBRegWrite && (MEMWBDst != REG_ADDR_W'(REG_ZERO));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_data_q <= '0;
            dst_q        <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_data_q <= write_data_d;
            dst_q        <= dst_d;
        end
    end

    assign MEMWBRegWriteOut = reg_write_q;
    assign MEMWBWriteData   = write_data_q;
    assign MEMWBDstOut      = dst_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          we_o;
    logic [DW-1:0] wd_o;
    logic [AW-1:0] dst_o;
    logic [AW-1:0] dst_i;
    logic [DW-1:0] alu_i;
    logic [DW-1:0] rd_i;
    logic          m2r_i;
    logic          rw_i;

    int errors = 0;
    int checks = 0;

    logic          model_valid = 1'b0;
    logic          exp_we;
    logic [DW-1:0] exp_wd;
    logic [AW-1:0] exp_dst;

    always #5 clock = ~clock;

    wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .MEMWBRegWriteOut (we_o),
        .MEMWBWriteData   (wd_o),
        .MEMWBDstOut      (dst_o),
        .MEMWBDst         (dst_i),
        .MEMWBALUResult   (alu_i),
        .MEMWBReadData    (rd_i),
        .MEMWBMemtoReg    (m2r_i),
        .MEMWBRegWrite    (rw_i),
        .clock            (clock),
        .reset            (reset)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what the register file must be told one edge after the inputs.
    always @(posedge clock) begin
        model_valid <= 1'b1;
        if (reset) begin
            exp_we  <= 1'b0;
            exp_wd  <= '0;
            exp_dst <= '0;
        end else begin
            exp_wd  <= (m2r_i == 1'b1) ? rd_i : alu_i;
            exp_dst <= dst_i;
            exp_we  <= (rw_i == 1'b1) && (dst_i != 0);
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            chk("model_we",  {31'b0, we_o}, {31'b0, exp_we});
            chk("model_wd",  wd_o, exp_wd);
            chk("model_dst", {27'b0, dst_o}, {27'b0, exp_dst});
        end
    end

    task automatic drive(input logic rst, input logic [AW-1:0] d, input logic [DW-1:0] a,
                         input logic [DW-1:0] r, input logic m, input logic w);
        reset = rst;
        dst_i = d;
        alu_i = a;
        rd_i  = r;
        m2r_i = m;
        rw_i  = w;
    endtask

    task automatic step(input logic rst, input logic [AW-1:0] d, input logic [DW-1:0] a,
                        input logic [DW-1:0] r, input logic m, input logic w);
        drive(rst, d, a, r, m, w);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic lit(input string nm, input logic we, input logic [DW-1:0] wd, input logic [AW-1:0] d);
        chk({nm, "_we"},  {31'b0, we_o}, {31'b0, we});
        chk({nm, "_wd"},  wd_o, wd);
        chk({nm, "_dst"}, {27'b0, dst_o}, {27'b0, d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 5'd31, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b1, 1'b1);
        @(posedge clock);
        @(negedge clock);
        lit("reset1", 1'b0, 32'h0, 5'd0);
        step(1'b1, 5'd31, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b1, 1'b1);
        lit("reset2", 1'b0, 32'h0, 5'd0);

        step(1'b0, 5'b01101, 32'h1235_7968, 32'h7654_3210, 1'b1, 1'b1);
        lit("mem_sel", 1'b1, 32'h7654_3210, 5'b01101);

        step(1'b0, 5'b01101, 32'h1235_7968, 32'h7654_3210, 1'b0, 1'b0);
        lit("alu_sel", 1'b0, 32'h1235_7968, 5'b01101);

        step(1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);
        lit("zero_dst", 1'b0, 32'hDEAD_BEEF, 5'd0);

        // Mid-cycle input changes must not reach the outputs before the next edge.
        drive(1'b0, 5'd7, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
        #2;
        lit("hold_a", 1'b0, 32'hDEAD_BEEF, 5'd0);
        drive(1'b0, 5'd9, 32'h3333_3333, 32'hAAAA_5555, 1'b1, 1'b1);
        #1;
        lit("hold_b", 1'b0, 32'hDEAD_BEEF, 5'd0);
        @(posedge clock);
        @(negedge clock);
        lit("mid_change", 1'b1, 32'hAAAA_5555, 5'd9);

        step(1'b0, 5'd3, 32'h0000_00C3, 32'h0, 1'b0, 1'b1);
        lit("pre_reset", 1'b1, 32'h0000_00C3, 5'd3);
        step(1'b1, 5'd3, 32'h0000_00C3, 32'h0, 1'b0, 1'b1);
        lit("mid_reset", 1'b0, 32'h0, 5'd0);
        step(1'b0, 5'd4, 32'h0000_0055, 32'h0000_0066, 1'b0, 1'b1);
        lit("post_reset", 1'b1, 32'h0000_0055, 5'd4);

        step(1'b0, 5'd31, 32'h8000_0001, 32'h7FFF_FFFE, 1'b1, 1'b1);
        lit("max_dst", 1'b1, 32'h7FFF_FFFE, 5'd31);

        for (int i = 0; i < 24; i++) begin
            step(1'b0, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
                 $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
